// File: rtl/hist_frame_ctrl.sv
// Frame sequencer for the 4-bit peak-count histogram: clears the histogram, gates
// a window of frame_len samples, waits out the compare pipeline, then hands the peak bin on.
module hist_frame_ctrl #(
  parameter int FRAME_W  = 13,
  parameter int PIPE_LAT = 5,
  parameter int ID_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               abort,
  input  logic               sample_valid,
  output logic               cm_en,
  output logic               cm_ready,
  input  logic               cm_valid,
  input  logic [3:0]         cm_max,
  output logic               peak_valid,
  input  logic               peak_ready,
  output logic [3:0]         peak_bin,
  output logic [ID_W-1:0]    peak_id,
  output logic               busy
);

  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, FETCH, OUT} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] len_q, len_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [ID_W-1:0]    fid_q, fid_d;
  logic [ID_W-1:0]    pid_q, pid_d;
  logic [3:0]         pbin_q, pbin_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      fid_q   <= '0;
      pid_q   <= '0;
      pbin_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      fid_q   <= fid_d;
      pid_q   <= pid_d;
      pbin_q  <= pbin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    drn_d    = drn_q;
    fid_d    = fid_q;
    pid_d    = pid_q;
    pbin_d   = pbin_q;
    cm_en    = 1'b0;
    cm_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d   = frame_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // The handshake itself zeroes the histogram counters.
        cm_ready = 1'b1;
        if (cm_valid) begin
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        cm_en = sample_valid;
        if (sample_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            drn_d   = DRN_INIT;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drn_q == '0) state_d = FETCH;
        else             drn_d   = drn_q - 1'b1;
      end
      FETCH: begin
        cm_ready = 1'b1;
        if (cm_valid) begin
          pbin_d  = cm_max;
          pid_d   = fid_q;
          state_d = OUT;
        end
      end
      OUT: begin
        if (peak_ready) begin
          fid_d   = fid_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort beats any same-cycle handshake; leftover counts are wiped by the next CLEAR.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      fid_d    = fid_q;
      pid_d    = pid_q;
      pbin_d   = pbin_q;
      cm_en    = 1'b0;
      cm_ready = 1'b0;
    end
  end

  assign peak_valid = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign peak_bin   = pbin_q;
  assign peak_id    = pid_q;

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Bench for hist_frame_ctrl: behavioural 16-bin histogram as the upstream block,
// a frame table plus hand-written corner sequences, results checked through a queue.
module tb_hist_frame_ctrl;

  localparam int FRAME_W  = 13;
  localparam int PIPE_LAT = 5;
  localparam int ID_W     = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [FRAME_W-1:0] frame_len;
  logic               abort;
  logic               sample_valid;
  logic               cm_en;
  logic               cm_ready;
  logic               cm_valid;
  logic [3:0]         cm_max;
  logic               peak_valid;
  logic               peak_ready;
  logic [3:0]         peak_bin;
  logic [ID_W-1:0]    peak_id;
  logic               busy;
  logic [3:0]         tdc_code;

  hist_frame_ctrl #(.FRAME_W(FRAME_W), .PIPE_LAT(PIPE_LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .abort(abort),
    .sample_valid(sample_valid), .cm_en(cm_en), .cm_ready(cm_ready), .cm_valid(cm_valid),
    .cm_max(cm_max), .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_bin(peak_bin),
    .peak_id(peak_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Histogram model: a handshake clears it, an enabled sample bumps its code's bin.
  int hcnt [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) hcnt[i] <= 0;
    end else if (cm_ready && cm_valid) begin
      for (int i = 0; i < 16; i++) hcnt[i] <= 0;
    end else if (cm_en) begin
      hcnt[tdc_code] <= hcnt[tdc_code] + 1;
    end
  end

  int best;
  always_comb begin
    best   = hcnt[0];
    cm_max = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (hcnt[i] > best) begin
        best   = hcnt[i];
        cm_max = i[3:0];
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_total = 0;
  logic [ID_W-1:0] exp_id = '0;

  typedef struct packed {
    logic [3:0]      bin;
    logic [ID_W-1:0] id;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("en_ready_exclusive", {31'd0, cm_en & cm_ready}, 32'd0);
      if (cm_en) en_total <= en_total + 1;
      if (peak_valid && peak_ready && !abort) begin
        if (sb.size() == 0) begin
          chk("unexpected_peak_valid", {31'd0, peak_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("peak_bin", {28'd0, peak_bin}, {28'd0, e.bin});
          chk("peak_id", {24'd0, peak_id}, {24'd0, e.id});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 abort in DRAIN, 2 abort with peak_ready in OUT, 3 back-pressure,
  //       4 start while busy, 5 start on OUT exit, 6 abort in ACCUM
  task automatic run_frame(input int len, input logic [39:0] codes, input bit gap,
                           input logic [3:0] exp_bin, input int mode);
    int t0, e0, guard, seen;
    logic [3:0] hb;
    logic [ID_W-1:0] hid;
    peak_ready = !(mode == 2 || mode == 3);
    frame_len  = FRAME_W'(len);
    start      = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    e0 = en_total;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_in_clear", {31'd0, cm_ready}, 32'd1);
    if (mode == 0 || mode == 3 || mode == 4 || mode == 5) begin
      sb.push_back('{bin: exp_bin, id: exp_id});
      exp_id = exp_id + 1'b1;
    end
    step();
    for (int i = 0; i < len; i++) begin
      sample_valid = 1'b1;
      tdc_code     = codes[4*i +: 4];
      if (mode == 4 && i == 1) begin
        start     = 1'b1;
        frame_len = FRAME_W'(1);
      end
      if (mode == 6 && i == 1) begin
        abort = 1'b1;
        #1;
        chk("abort_forces_en_low", {31'd0, cm_en}, 32'd0);
        step();
        abort = 1'b0;
        sample_valid = 1'b0;
        chk("abort_accum_idle", {31'd0, busy}, 32'd0);
        return;
      end
      step();
      start = 1'b0;
      if (gap && i != len - 1) begin
        sample_valid = 1'b0;
        step();
      end
    end
    sample_valid = 1'b0;
    chk("enabled_samples", en_total - e0, len);
    if (mode == 1) begin
      step();
      step();
      chk("drain_no_enable", {30'd0, cm_en, cm_ready}, 32'd0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_drain_idle", {31'd0, busy}, 32'd0);
      seen = 0;
      repeat (10) begin
        step();
        if (peak_valid) seen = 1;
      end
      chk("abort_no_peak_valid", seen, 0);
      return;
    end
    guard = 0;
    while (!peak_valid && guard < 60) begin
      step();
      guard++;
    end
    chk("start_to_peak_latency", cyc - t0 + 1, len + 8 + (gap ? len - 1 : 0));
    if (mode == 5) begin
      start     = 1'b1;
      frame_len = FRAME_W'(2);
      step();
      start = 1'b0;
      chk("start_on_exit_ignored", {31'd0, busy}, 32'd0);
      step();
      chk("still_idle", {31'd0, busy}, 32'd0);
    end else if (mode == 3) begin
      hb  = peak_bin;
      hid = peak_id;
      repeat (20) begin
        step();
        chk("bp_hold", {19'd0, peak_valid, peak_bin, peak_id}, {19'd0, 1'b1, hb, hid});
      end
      peak_ready = 1'b1;
      step();
      chk("bp_release", {31'd0, peak_valid}, 32'd0);
    end else if (mode == 2) begin
      repeat (3) step();
      abort      = 1'b1;
      peak_ready = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_out_dropped", {30'd0, busy, peak_valid}, 32'd0);
    end else begin
      step();
      chk("peak_valid_one_cycle", {31'd0, peak_valid}, 32'd0);
      chk("idle_after_out", {31'd0, busy}, 32'd0);
    end
  endtask

  typedef struct {
    int          len;
    logic [39:0] codes;
    bit          gap;
    logic [3:0]  exp_bin;
  } frame_t;
  frame_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{len: 10, codes: 40'h9377313733, gap: 1'b0, exp_bin: 4'd3};
    tbl[1] = '{len: 3,  codes: 40'h662,        gap: 1'b1, exp_bin: 4'd6};
    tbl[2] = '{len: 4,  codes: 40'h1111,       gap: 1'b0, exp_bin: 4'd1};
    tbl[3] = '{len: 7,  codes: 40'h499F0FF,    gap: 1'b0, exp_bin: 4'd15};
    tbl[4] = '{len: 1,  codes: 40'hC,          gap: 1'b0, exp_bin: 4'd12};

    rst = 1'b1; start = 1'b0; frame_len = '0; abort = 1'b0; sample_valid = 1'b0;
    cm_valid = 1'b1; peak_ready = 1'b1; tdc_code = '0;
    step();
    step();
    chk("reset_outputs", {15'd0, cm_en, cm_ready, peak_valid, peak_bin, peak_id, busy}, 32'd0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 5; k++)
      run_frame(tbl[k].len, tbl[k].codes, tbl[k].gap, tbl[k].exp_bin, 0);

    // asynchronous reset in the middle of ACCUM
    frame_len = FRAME_W'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    sample_valid = 1'b1;
    tdc_code = 4'd2;
    step();
    chk("en_before_reset", {31'd0, cm_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {15'd0, cm_en, cm_ready, peak_valid, peak_bin, peak_id, busy}, 32'd0);
    step();
    rst = 1'b0;
    sample_valid = 1'b0;
    exp_id = '0;
    run_frame(4, 40'h8288, 1'b0, 4'd8, 0);

    frame_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_len_ignored", {31'd0, busy}, 32'd0);
    step();

    run_frame(3, 40'h3AA, 1'b0, 4'd10, 4);
    run_frame(2, 40'hEE, 1'b0, 4'd14, 5);
    run_frame(5, 40'h66B66, 1'b0, 4'd6, 3);
    run_frame(4, 40'h2222, 1'b0, 4'd2, 6);
    run_frame(6, 40'h777777, 1'b0, 4'd7, 1);
    run_frame(2, 40'h55, 1'b0, 4'd5, 0);
    run_frame(3, 40'h111, 1'b0, 4'd1, 2);
    run_frame(2, 40'h44, 1'b0, 4'd4, 0);

    for (int k = 0; k < 256; k++) begin
      logic [3:0] c;
      c = k[3:0];
      run_frame(1, {36'd0, c}, 1'b0, c, 0);
    end

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
